// File: rtl/immgen_pipe_pkg.sv
// rtl/immgen_pipe_pkg.sv - immediate type codes, occupancy states and buffer entry metadata
`ifndef IMMGEN_DEFINES_VH
`define IMMGEN_DEFINES_VH
`define IMM_TYPE_W 3
`define I_TYPE 3'd0
`define S_TYPE 3'd1
`define B_TYPE 3'd2
`define U_TYPE 3'd3
`define J_TYPE 3'd4
`define Z_TYPE 3'd5
`endif

package immgen_pipe_pkg;

    localparam int IMM_TYPE_W = `IMM_TYPE_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [IMM_TYPE_W-1:0] imm_type;
        logic                  illegal;
    } meta_t;

endpackage

// File: rtl/immgen_pipe_decode.sv
// rtl/immgen_pipe_decode.sv - combinational RV immediate decoder; zimm gated by IMMGEN_ZIMM_EN
module imm_decode
    import immgen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           inst,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal
);
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            unused_opcode;

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign unused_opcode = ^inst[6:0];

`ifdef IMMGEN_ZIMM_EN
    localparam int NR_KEY = 6;
    logic [XLEN-1:0] imm_z;
    assign imm_z = XLEN'(inst[19:15]);

    MuxKeyWithDefault #(.NR_KEY(NR_KEY), .KEY_LEN(IMM_TYPE_W), .DATA_LEN(XLEN)) u_imm_mux (
        .out         (imm),
        .key         (imm_type),
        .default_out ({XLEN{1'b0}}),
        .lut         ({`Z_TYPE, imm_z, `J_TYPE, imm_j, `U_TYPE, imm_u,
                       `B_TYPE, imm_b, `S_TYPE, imm_s, `I_TYPE, imm_i})
    );
    MuxKeyWithDefault #(.NR_KEY(NR_KEY), .KEY_LEN(IMM_TYPE_W), .DATA_LEN(1)) u_ill_mux (
        .out         (illegal),
        .key         (imm_type),
        .default_out (1'b1),
        .lut         ({`Z_TYPE, 1'b0, `J_TYPE, 1'b0, `U_TYPE, 1'b0,
                       `B_TYPE, 1'b0, `S_TYPE, 1'b0, `I_TYPE, 1'b0})
    );
`else
    localparam int NR_KEY = 5;

    MuxKeyWithDefault #(.NR_KEY(NR_KEY), .KEY_LEN(IMM_TYPE_W), .DATA_LEN(XLEN)) u_imm_mux (
        .out         (imm),
        .key         (imm_type),
        .default_out ({XLEN{1'b0}}),
        .lut         ({`J_TYPE, imm_j, `U_TYPE, imm_u,
                       `B_TYPE, imm_b, `S_TYPE, imm_s, `I_TYPE, imm_i})
    );
    MuxKeyWithDefault #(.NR_KEY(NR_KEY), .KEY_LEN(IMM_TYPE_W), .DATA_LEN(1)) u_ill_mux (
        .out         (illegal),
        .key         (imm_type),
        .default_out (1'b1),
        .lut         ({`J_TYPE, 1'b0, `U_TYPE, 1'b0,
                       `B_TYPE, 1'b0, `S_TYPE, 1'b0, `I_TYPE, 1'b0})
    );
`endif
endmodule

// File: rtl/mux_key_with_default.sv
// rtl/mux_key_with_default.sv - keyed lookup mux returning default_out when no key matches
module MuxKeyWithDefault #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                      out,
    input  logic [KEY_LEN-1:0]                       key,
    input  logic [DATA_LEN-1:0]                      default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]     lut
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Each lut pair is {key, data}, pair 0 in the least significant bits.
    always_comb begin
        out = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            if (key == lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN]) begin
                out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end
endmodule

// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - registered immediate generator with 2-entry handshake buffer (IMMGEN_ZIMM_EN enables zimm)
module immgen_pipe
    import immgen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       imm,
    output logic [IMM_TYPE_W-1:0] imm_type_o,
    output logic                  illegal
);
    occ_e            state_q, state_d;
    logic [XLEN-1:0] imm_q [2];
    meta_t           meta_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst     (inst),
        .imm_type (imm_type),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (pop && !push) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready comes only from state_q so out_ready never reaches the upstream stage combinationally.
    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]  <= '0;
                meta_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                imm_q[wr_ptr_q]  <= dec_imm;
                meta_q[wr_ptr_q] <= '{imm_type: imm_type, illegal: dec_illegal};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign imm        = imm_q[rd_ptr_q];
    assign imm_type_o = meta_q[rd_ptr_q].imm_type;
    assign illegal    = meta_q[rd_ptr_q].illegal;
endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - random and directed checks of immgen_pipe (XLEN 32 and 64) against a queue model
module tb_immgen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [2:0]  imm_type = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [2:0]  type32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  type64;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  t;
        logic        ill;
    } exp_t;
    exp_t model_q[$];

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .imm_type(imm_type), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .imm_type_o(type32), .illegal(illegal32)
    );

    immgen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .imm_type(imm_type), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .imm_type_o(type64), .illegal(illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected immediate at 64 bits; the 32-bit result is its low half.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t, output logic ill);
        longint v;
        ill = 1'b0;
        case (t)
            3'd0: v = longint'($signed(w[31:20]));
            3'd1: v = longint'($signed({w[31:25], w[11:7]}));
            3'd2: v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'd3: v = longint'($signed({w[31:12], 12'h000}));
            3'd4: v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
`ifdef IMMGEN_ZIMM_EN
            3'd5: v = longint'({59'd0, w[19:15]});
`endif
            default: begin
                v = 0;
                ill = 1'b1;
            end
        endcase
        return v;
    endfunction

    task automatic compare_all();
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, model_q.size() > 0});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, model_q.size() > 0});
        chk("in_ready32", {63'd0, in_ready32}, {63'd0, model_q.size() < 2});
        chk("in_ready64", {63'd0, in_ready64}, {63'd0, model_q.size() < 2});
        if (model_q.size() > 0) begin
            chk("imm32", {32'd0, imm32}, {32'd0, model_q[0].imm[31:0]});
            chk("imm64", imm64, model_q[0].imm);
            chk("type32", {61'd0, type32}, {61'd0, model_q[0].t});
            chk("type64", {61'd0, type64}, {61'd0, model_q[0].t});
            chk("illegal32", {63'd0, illegal32}, {63'd0, model_q[0].ill});
            chk("illegal64", {63'd0, illegal64}, {63'd0, model_q[0].ill});
        end
    endtask

    // Called at a falling edge: drive, advance the model across the next rising edge, then compare.
    task automatic step(input logic v, input logic [31:0] w, input logic [2:0] t,
                        input logic r, input logic f);
        exp_t e;
        logic do_push, do_pop;
        in_valid  = v;
        inst      = w;
        imm_type  = t;
        out_ready = r;
        flush     = f;
        do_push = v && (model_q.size() < 2);
        do_pop  = r && (model_q.size() > 0);
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.imm = ref_imm(w, t, e.ill);
                e.t   = t;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid32 | out_valid64}, 64'd0);
        chk({tag, "_in_ready"}, {62'd0, in_ready32, in_ready64}, 64'd3);
        chk({tag, "_imm"}, imm64 | {32'd0, imm32}, 64'd0);
        chk({tag, "_type"}, {58'd0, type32, type64}, 64'd0);
        chk({tag, "_illegal"}, {62'd0, illegal32, illegal64}, 64'd0);
    endtask

    function automatic logic [31:0] itype(input logic [11:0] k);
        return {k, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    initial begin
        logic ill;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        compare_all();

        step(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        chk("i_type_imm32", {32'd0, imm32}, 64'hFFFFFFFF);
        chk("i_type_illegal", {63'd0, illegal32}, 64'd0);

        step(1'b1, 32'hFE112E23, 3'd1, 1'b1, 1'b0);
        chk("s_type_imm32", {32'd0, imm32}, 64'hFFFFFFFC);
        step(1'b1, 32'hFE000CE3, 3'd2, 1'b1, 1'b0);
        chk("b_type_imm32", {32'd0, imm32}, 64'hFFFFFFF8);

        step(1'b1, 32'h800000B7, 3'd3, 1'b1, 1'b0);
        chk("u_type_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("u_type_imm32", {32'd0, imm32}, 64'h80000000);

        step(1'b1, 32'h12345013, 3'd7, 1'b1, 1'b0);
        chk("unknown_imm", imm64, 64'd0);
        chk("unknown_illegal", {63'd0, illegal64}, 64'd1);

        step(1'b1, {12'h000, 5'h1F, 3'b101, 5'd1, 7'h73}, 3'd5, 1'b1, 1'b0);
`ifdef IMMGEN_ZIMM_EN
        chk("zimm_imm", imm64, 64'h1F);
        chk("zimm_illegal", {63'd0, illegal64}, 64'd0);
`else
        chk("zimm_off_imm", imm64, 64'd0);
        chk("zimm_off_illegal", {63'd0, illegal64}, 64'd1);
`endif
        step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Back-pressure: third instruction must wait, head must hold.
        step(1'b1, itype(12'd1), 3'd0, 1'b0, 1'b0);
        step(1'b1, itype(12'd2), 3'd0, 1'b0, 1'b0);
        chk("bp_in_ready_full", {63'd0, in_ready32}, 64'd0);
        step(1'b1, itype(12'd3), 3'd0, 1'b0, 1'b0);
        chk("bp_hold_imm", {32'd0, imm32}, 64'd1);
        step(1'b1, itype(12'd3), 3'd0, 1'b1, 1'b0);
        chk("bp_second_imm", {32'd0, imm32}, 64'd2);
        step(1'b1, itype(12'd3), 3'd0, 1'b1, 1'b0);
        chk("bp_third_imm", {32'd0, imm32}, 64'd3);
        step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        chk("bp_drained", {63'd0, out_valid32}, 64'd0);

        // Flush while full, with a concurrent instruction.
        step(1'b1, itype(12'd10), 3'd0, 1'b0, 1'b0);
        step(1'b1, itype(12'd11), 3'd0, 1'b0, 1'b0);
        step(1'b1, itype(12'd12), 3'd0, 1'b0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid64}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready64}, 64'd1);
        step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        chk("flush_no_ghost", {63'd0, out_valid64}, 64'd0);

        // Asynchronous reset between edges while full.
        step(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h800000B7, 3'd3, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        #1 rst = 1'b0;
        model_q.delete();
        @(negedge clk);
        compare_all();

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Registered, parametrised immediate generator between the fetch/decode boundary and the execute stage. Takes an instruction word and a 3-bit immediate type and decodes every RV32/RV64 base immediate format (I, S, B, U, J, plus optional CSR zimm), sign-extended to XLEN. Results sit in a 2-entry in-order buffer with valid/ready handshakes on both sides, so execute back-pressure stalls decode without losing an instruction.

## Interface
- XLEN, 32: output immediate width; legal values 32 and 64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  input  1  an instruction is presented.
- in_ready  output  1  the block accepts an instruction this cycle.
- inst  input  32  instruction word.
- imm_type  input  3  format select, encoded as in defines.vh.
- out_valid  output  1  the head entry is valid.
- out_ready  input  1  the consumer takes the head entry this cycle.
- imm  output  XLEN  decoded immediate of the head entry.
- imm_type_o  output  3  imm_type carried with the head entry.
- illegal  output  1  the head entry had an unrecognised imm_type.

## Operation
- Type codes: I=0, S=1, B=2, U=3, J=4, Z=5; codes 6 and 7 are unknown.
- I: sext(inst[31:20]).
- S: sext({inst[31:25], inst[11:7]}).
- B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- U: sext({inst[31:12], 12'b0}). With XLEN=64, bits 63:32 copy inst[31].
- J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Z: zext(inst[19:15]).
- sext and zext extend to XLEN.
- Unknown type: imm=0 and illegal=1. Otherwise illegal=0.
- Buffer: 2-entry FIFO with fields {imm, imm_type, illegal}. Occupancy state is one of EMPTY, ONE or FULL.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: push → ONE.
- ONE: push only → FULL; pop only → EMPTY; push and pop together → ONE, with the new entry becoming head.
- FULL: pop → ONE. Push cannot occur in FULL.
- in_ready = (state != FULL). It is driven from registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- imm, imm_type_o and illegal always show the head entry. They hold their value while out_valid=1 and out_ready=0.
- flush has priority over push and pop. The next state is EMPTY, and an instruction presented in the same cycle is discarded.

## Timing
- Reset values:
  - out_valid=0, imm=0, imm_type_o=0, illegal=0, in_ready=1.
  - Both buffer entries and the read/write pointers are cleared.
- Reset asserted mid-operation empties the buffer immediately, without waiting for a clock edge.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N, independent of out_ready.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Ordering: strictly FIFO. A pointer wraps from entry 1 back to entry 0.
- Decode is combinational on inst and imm_type and is registered only at the buffer write.

## Configuration
- IMMGEN_ZIMM_EN defined: type 5 decodes as zimm, with illegal=0.
- IMMGEN_ZIMM_EN undefined: type 5 is treated as unknown, giving imm=0 and illegal=1.

## Structure
- defines.vh holds the `define type codes:
  - I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, Z_TYPE, each 3 bits wide.
  - IMM_TYPE_W = 3.
- Sub-module imm_decode (combinational, parametrised by XLEN):
  - Inputs: inst, imm_type.
  - Outputs: imm, illegal.
  - Built on MuxKeyWithDefault with default 0.
- immgen_pipe holds the buffer, the pointers and the occupancy state machine.

## Test plan
- I-type, inst=0xFFF00093, type=I, out_ready=1 → one cycle later imm=0xFFFFFFFF, illegal=0.
- S-type and B-type, back to back: inst=0xFE112E23 (S) then 0xFE000CE3 (B) → imm=0xFFFFFFFC, then 0xFFFFFFF8, on consecutive cycles.
- U-type, XLEN=64, inst=0x800000B7 → imm=0xFFFFFFFF80000000. Same instruction with XLEN=32 → imm=0x80000000.
- Back-pressure: out_ready=0, present three I-type instructions with imm 1, 2, 3:
  - The first two are accepted; in_ready=0 from the cycle after the second push.
  - After raising out_ready, the outputs are 1, 2, 3 in order, and imm stays stable while stalled.
- Unknown and zimm: type=7 → imm=0, illegal=1. Type=5 with inst[19:15]=0x1F → imm=0x1F when IMMGEN_ZIMM_EN is defined; otherwise illegal=1.
- Flush and reset with the buffer FULL:
  - flush=1 together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the concurrent instruction never appears.
  - rst pulsed between clock edges → all outputs take their reset values immediately.
